// File: rtl/multi_channel_counter_if.sv
// Control and status bundle for multi_channel_counter.
// The slave modport faces the counter block; the master modport faces the controller.
interface multi_channel_counter_if #(
   parameter int WIDTH  = 4,
   parameter int NUM_CH = 2,
   parameter int STEP_W = 4
);
   localparam int TOTAL_W = WIDTH + $clog2(NUM_CH) + 1;

   logic [NUM_CH-1:0]       ch_enable;
   logic [NUM_CH-1:0]       ch_load;
   logic [NUM_CH-1:0]       ch_down;
   logic [NUM_CH*WIDTH-1:0] load_value;
   logic [STEP_W-1:0]       step;
   logic                    sat_mode;
   logic                    clear_flags;
   logic [NUM_CH*WIDTH-1:0] count;
   logic [NUM_CH-1:0]       overflow;
   logic [NUM_CH-1:0]       overflow_sticky;
   logic [TOTAL_W-1:0]      total;
   logic                    total_valid;

   modport slave (
      input  ch_enable, ch_load, ch_down, load_value, step, sat_mode, clear_flags,
      output count, overflow, overflow_sticky, total, total_valid
   );

   modport master (
      output ch_enable, ch_load, ch_down, load_value, step, sat_mode, clear_flags,
      input  count, overflow, overflow_sticky, total, total_valid
   );
endinterface

// File: rtl/multi_channel_counter.sv
// NUM_CH independent up/down step counters with wrap or saturate, parallel load,
// per-channel overflow pulse and sticky flags, plus a registered sum of all counts.
module multi_channel_counter #(
   parameter int WIDTH  = 4,
   parameter int NUM_CH = 2,
   parameter int STEP_W = 4
) (
   input  logic                    clk,
   input  logic                    reset_n,
   multi_channel_counter_if.slave  bus
);
   localparam int TOTAL_W = WIDTH + $clog2(NUM_CH) + 1;

   logic [WIDTH-1:0]   count_arr [NUM_CH];
   logic [WIDTH:0]     step_ext;
   logic [TOTAL_W-1:0] total_q, total_d;
   logic               valid_pipe_q;
   logic               total_valid_q;

   assign step_ext = (WIDTH+1)'(bus.step);

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
         logic [WIDTH-1:0] cnt_q, cnt_d;
         logic             ovf_q, ovf_d;
         logic             sticky_q, sticky_d;
         logic [WIDTH:0]   up_sum;
         logic [WIDTH:0]   down_diff;

         // The extra MSB of each result is the carry (up) or borrow (down).
         assign up_sum    = {1'b0, cnt_q} + step_ext;
         assign down_diff = {1'b0, cnt_q} - step_ext;

         always_comb begin
            cnt_d = cnt_q;
            ovf_d = 1'b0;
            if (bus.ch_load[gi]) begin
               cnt_d = bus.load_value[gi*WIDTH +: WIDTH];
            end else if (bus.ch_enable[gi]) begin
               if (bus.ch_down[gi]) begin
                  ovf_d = down_diff[WIDTH];
                  cnt_d = (down_diff[WIDTH] && bus.sat_mode) ? '0 : down_diff[WIDTH-1:0];
               end else begin
                  ovf_d = up_sum[WIDTH];
                  cnt_d = (up_sum[WIDTH] && bus.sat_mode) ? '1 : up_sum[WIDTH-1:0];
               end
            end
            sticky_d = ovf_d ? 1'b1 : (bus.clear_flags ? 1'b0 : sticky_q);
         end

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               cnt_q    <= '0;
               ovf_q    <= 1'b0;
               sticky_q <= 1'b0;
            end else begin
               cnt_q    <= cnt_d;
               ovf_q    <= ovf_d;
               sticky_q <= sticky_d;
            end
         end

         assign count_arr[gi]                  = cnt_q;
         assign bus.count[gi*WIDTH +: WIDTH]   = cnt_q;
         assign bus.overflow[gi]               = ovf_q;
         assign bus.overflow_sticky[gi]        = sticky_q;
      end
   endgenerate

   always_comb begin
      total_d = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         total_d = total_d + TOTAL_W'(count_arr[i]);
      end
   end

   // valid_pipe_q rises on the first edge after release, total_valid_q on the second.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         total_q       <= '0;
         valid_pipe_q  <= 1'b0;
         total_valid_q <= 1'b0;
      end else begin
         total_q       <= total_d;
         valid_pipe_q  <= 1'b1;
         total_valid_q <= valid_pipe_q;
      end
   end

   assign bus.total       = total_q;
   assign bus.total_valid = total_valid_q;
endmodule
